// File: rtl/sprite_draw_arbiter.sv
// sprite_draw_arbiter
// Round-robin arbiter that shares one VGA plot port between several sprite
// requesters. The winner's base position and colour are latched, then a fixed
// SPR_W x SPR_H rectangle is walked row-major, one pixel per clock, with
// off-screen pixels suppressed (they still take their cycle).
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset
//   req         per-requester draw request, held until the matching done
//   req_x       packed 8-bit base x per requester (slice i = [8i+7:8i])
//   req_y       packed 7-bit base y per requester (slice i = [7i+6:7i])
//   req_colour  packed 3-bit colour per requester (slice i = [3i+2:3i])
//   grant       one-hot, high from LATCH through the last DRAW cycle
//   done        one-cycle pulse on the served index after its rectangle
//   vga_x/vga_y/vga_colour/plot  pixel stream to the VGA adapter
//   busy        high whenever the block is not idle
module sprite_draw_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SPR_W   = 8,
  parameter int SPR_H   = 4,
  parameter int SCR_W   = 160,
  parameter int SCR_H   = 120
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_x,
  input  logic [7*NUM_REQ-1:0]   req_y,
  input  logic [3*NUM_REQ-1:0]   req_colour,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   plot,
  output logic                   busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_DRAW, S_DONE} state_t;

  state_t          state_q;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   win_q;
  logic [7:0]      base_x_q;
  logic [6:0]      base_y_q;
  logic [2:0]      colour_q;
  logic [3:0]      cx_q;
  logic [3:0]      cy_q;

  // Unpacked views of the packed per-requester buses.
  logic [7:0] slice_x [NUM_REQ];
  logic [6:0] slice_y [NUM_REQ];
  logic [2:0] slice_c [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign slice_x[gi] = req_x[8*gi +: 8];
    assign slice_y[gi] = req_y[7*gi +: 7];
    assign slice_c[gi] = req_colour[3*gi +: 3];
  end

  // Round-robin search starting just after the last served index. The loop
  // runs from the farthest candidate to the nearest so the nearest set bit
  // is the one left standing.
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Row-major step of the rectangle counters.
  logic [3:0] cx_d;
  logic [3:0] cy_d;
  logic       last_px;

  always_comb begin
    last_px = (cx_q == 4'(SPR_W - 1)) && (cy_q == 4'(SPR_H - 1));
    if (cx_q == 4'(SPR_W - 1)) begin
      cx_d = 4'd0;
      cy_d = cy_q + 4'd1;
    end else begin
      cx_d = cx_q + 4'd1;
      cy_d = cy_q;
    end
  end

  // Pixel about to be presented: (0,0) when leaving LATCH, the next scan
  // position while in DRAW. Sums are kept one bit wide so clipping sees the
  // untruncated coordinate.
  logic [3:0] emit_cx;
  logic [3:0] emit_cy;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       in_screen;

  always_comb begin
    emit_cx   = (state_q == S_DRAW) ? cx_d : cx_q;
    emit_cy   = (state_q == S_DRAW) ? cy_d : cy_q;
    sum_x     = {1'b0, base_x_q} + {5'b0, emit_cx};
    sum_y     = {1'b0, base_y_q} + {4'b0, emit_cy};
    in_screen = (int'(sum_x) < SCR_W) && (int'(sum_y) < SCR_H);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      last_q     <= IW'(NUM_REQ - 1);
      win_q      <= '0;
      base_x_q   <= '0;
      base_y_q   <= '0;
      colour_q   <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      grant      <= '0;
      done       <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done <= '0;
          if (win_found) begin
            win_q    <= win_idx;
            base_x_q <= slice_x[win_idx];
            base_y_q <= slice_y[win_idx];
            colour_q <= slice_c[win_idx];
            cx_q     <= '0;
            cy_q     <= '0;
            grant    <= NUM_REQ'(1) << win_idx;
            busy     <= 1'b1;
            state_q  <= S_LATCH;
          end
        end
        S_LATCH: begin
          vga_x      <= sum_x[7:0];
          vga_y      <= sum_y[6:0];
          vga_colour <= colour_q;
          plot       <= in_screen;
          state_q    <= S_DRAW;
        end
        S_DRAW: begin
          if (last_px) begin
            plot    <= 1'b0;
            grant   <= '0;
            done    <= grant;
            state_q <= S_DONE;
          end else begin
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            vga_x      <= sum_x[7:0];
            vga_y      <= sum_y[6:0];
            vga_colour <= colour_q;
            plot       <= in_screen;
          end
        end
        S_DONE: begin
          done    <= '0;
          busy    <= 1'b0;
          last_q  <= win_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Testbench for sprite_draw_arbiter: directed table of single-requester
// rectangles, hand-written multi-cycle sequences, then randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_sprite_draw_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int WH = W * H;
  localparam int SW = 160;
  localparam int SH = 120;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [11:0] req_colour;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;
  logic        busy;

  always #5 clk = ~clk;

  sprite_draw_arbiter #(
    .NUM_REQ(N), .SPR_W(W), .SPR_H(H), .SCR_W(SW), .SCR_H(SH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .grant(grant), .done(done), .vga_x(vga_x),
    .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int step_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at step %0d: got 0x%0h, expected 0x%0h", name, step_no, act, exp);
    end
  endtask

  // ---------------- reference model (transaction schedule) ----------------
  // A served request occupies: LATCH at offset 0, pixels at offsets 1..WH,
  // done at WH+1, then one idle cycle before the next arbitration.
  bit   m_active = 1'b0;
  int   m_d = 0;
  int   m_w = 0;
  int   m_last = N - 1;
  int   m_bx = 0, m_by = 0, m_col = 0;
  bit   m_rst_seen = 1'b0;
  logic [3:0] e_grant = '0, e_done = '0;
  bit   e_plot = 1'b0, e_busy = 1'b0, e_draw = 1'b0;
  int   e_x = 0, e_y = 0, e_col = 0;

  task automatic model_edge(input logic s_rst, input logic [3:0] s_req,
                            input logic [31:0] s_x, input logic [27:0] s_y,
                            input logic [11:0] s_c);
    int  p, sx, sy, c;
    bit  found;
    m_rst_seen = 1'b0;
    if (!s_rst) begin
      m_active   = 1'b0;
      m_last     = N - 1;
      m_rst_seen = 1'b1;
    end else if (m_active) begin
      m_d++;
      if (m_d == WH + 2) begin
        m_active = 1'b0;
        m_last   = m_w;
      end
    end else if (s_req != 4'b0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && s_req[c]) begin
          found = 1'b1;
          m_w   = c;
        end
      end
      m_bx     = int'(s_x[8*m_w +: 8]);
      m_by     = int'(s_y[7*m_w +: 7]);
      m_col    = int'(s_c[3*m_w +: 3]);
      m_active = 1'b1;
      m_d      = 0;
    end
    e_grant = '0; e_done = '0; e_plot = 1'b0; e_busy = 1'b0; e_draw = 1'b0;
    if (m_active) begin
      e_busy = (m_d <= WH + 1);
      if (m_d <= WH) e_grant = 4'(1 << m_w);
      if (m_d == WH + 1) e_done = 4'(1 << m_w);
      if (m_d >= 1 && m_d <= WH) begin
        p      = m_d - 1;
        sx     = m_bx + p % W;
        sy     = m_by + p / W;
        e_draw = 1'b1;
        e_plot = (sx < SW) && (sy < SH);
        e_x    = sx % 256;
        e_y    = sy % 128;
        e_col  = m_col;
      end
    end
  endtask

  // One clock: snapshot inputs, advance model at the edge, check 1ns later.
  task automatic step();
    logic        s_rst;
    logic [3:0]  s_req;
    logic [31:0] s_x;
    logic [27:0] s_y;
    logic [11:0] s_c;
    s_rst = reset_n; s_req = req; s_x = req_x; s_y = req_y; s_c = req_colour;
    @(posedge clk);
    model_edge(s_rst, s_req, s_x, s_y, s_c);
    #1;
    step_no++;
    chk("grant", 32'(grant), 32'(e_grant));
    chk("done", 32'(done), 32'(e_done));
    chk("plot", 32'(plot), 32'(e_plot));
    chk("busy", 32'(busy), 32'(e_busy));
    if (e_draw) begin
      chk("vga_x", 32'(vga_x), 32'(e_x));
      chk("vga_y", 32'(vga_y), 32'(e_y));
      chk("vga_colour", 32'(vga_colour), 32'(e_col));
    end
    if (m_rst_seen) begin
      chk("rst_vga_x", 32'(vga_x), 32'd0);
      chk("rst_vga_y", 32'(vga_y), 32'd0);
      chk("rst_vga_colour", 32'(vga_colour), 32'd0);
    end
  endtask

  task automatic set_data(input int i, input int x, input int y, input int c);
    req_x[8*i +: 8]      = 8'(x);
    req_y[7*i +: 7]      = 7'(y);
    req_colour[3*i +: 3] = 3'(c);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] rq;
    int x, y, col, nplot;
    int fx, fy, mx, my, lx, ly;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int np, idx, ng, last_done;

    tbl[0] = '{4'b0001,  10,  20, 4, 32,  10,  20,  10,  21,  17,  23};
    tbl[1] = '{4'b0100, 156, 118, 3,  8, 156, 118, 156, 119, 163, 121};
    tbl[2] = '{4'b0010, 152, 116, 6, 32, 152, 116, 152, 117, 159, 119};
    tbl[3] = '{4'b1000, 250, 126, 7,  0, 250, 126, 250, 127,   1,   1};
    tbl[4] = '{4'b0001,   0,   0, 1, 32,   0,   0,   0,   1,   7,   3};

    reset_n = 1'b0; req = '0; req_x = '0; req_y = '0; req_colour = '0;
    do_reset();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant", 32'(grant), 32'd0);

    for (int r = 0; r < 5; r++) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (tbl[r].rq[i]) idx = i;
      set_data(idx, tbl[r].x, tbl[r].y, tbl[r].col);
      req = tbl[r].rq;
      np  = 0;
      for (int s = 1; s <= WH + 2; s++) begin
        step();
        if (s == 1) chk("tbl_grant", 32'(grant), 32'(tbl[r].rq));
        if (s >= 2 && s <= WH + 1 && plot) np++;
        if (s == 2) begin
          chk("tbl_first_x", 32'(vga_x), 32'(tbl[r].fx));
          chk("tbl_first_y", 32'(vga_y), 32'(tbl[r].fy));
          chk("tbl_colour", 32'(vga_colour), 32'(tbl[r].col));
        end
        if (s == 10) begin
          chk("tbl_pix8_x", 32'(vga_x), 32'(tbl[r].mx));
          chk("tbl_pix8_y", 32'(vga_y), 32'(tbl[r].my));
        end
        if (s == WH + 1) begin
          chk("tbl_last_x", 32'(vga_x), 32'(tbl[r].lx));
          chk("tbl_last_y", 32'(vga_y), 32'(tbl[r].ly));
        end
        if (s == WH + 2) chk("tbl_done", 32'(done), 32'(tbl[r].rq));
      end
      chk("tbl_nplot", 32'(np), 32'(tbl[r].nplot));
      $display("[TB] table row %0d: req=%b plotted %0d", r, tbl[r].rq, np);
      req = '0;
      step();
      step();
    end

    // ---- round-robin with all requests held ----
    do_reset();
    for (int i = 0; i < N; i++) set_data(i, 20 * i, 10 * i, i + 1);
    req = 4'b1111;
    ng = 0; last_done = 0;
    for (int s = 1; s <= 5 * (WH + 3); s++) begin
      logic [3:0] prev_grant;
      prev_grant = grant;
      step();
      if (grant != 4'b0 && prev_grant == 4'b0) begin
        chk("rr_order", 32'(grant), 32'(1 << (ng % N)));
        if (ng > 0) chk("rr_gap", 32'(step_no - last_done), 32'd2);
        ng++;
      end
      if (done != 4'b0) last_done = step_no;
    end
    chk("rr_grants", 32'(ng), 32'd5);
    $display("[TB] round-robin sequence: %0d grants", ng);
    req = '0;
    for (int s = 0; s < 40; s++) step();

    // ---- request dropped and position changed mid-draw ----
    set_data(1, 40, 30, 5);
    req = 4'b0010;
    for (int s = 1; s <= WH + 2; s++) begin
      if (s == 7) begin
        req = '0;
        req_x[15:8] = 8'd100;
      end
      step();
      if (s == WH + 1) begin
        chk("drop_last_x", 32'(vga_x), 32'd47);
        chk("drop_last_y", 32'(vga_y), 32'd33);
      end
      if (s == WH + 2) chk("drop_done", 32'(done), 32'b0010);
    end
    $display("[TB] mid-draw drop sequence complete");
    for (int s = 0; s < 3; s++) step();

    // ---- reset during the 10th DRAW cycle ----
    set_data(3, 20, 20, 2);
    req = 4'b1000;
    for (int s = 1; s <= 11; s++) begin
      step();
      if (s == 1) chk("rst_mid_grant", 32'(grant), 32'b1000);
    end
    reset_n = 1'b0;
    step();
    chk("rst_mid_plot", 32'(plot), 32'd0);
    chk("rst_mid_grant0", 32'(grant), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    step();
    chk("rst_regrant", 32'(grant), 32'b1000);
    for (int s = 1; s <= WH + 1; s++) begin
      step();
      if (s == WH + 1) chk("rst_regrant_done", 32'(done), 32'b1000);
    end
    $display("[TB] reset mid-draw sequence complete");
    req = '0;
    for (int s = 0; s < 3; s++) step();

    // ---- fairness: requester 1 served, then 0 before 1 again ----
    set_data(1, 60, 60, 3);
    req = 4'b0010;
    step();
    chk("fair_first", 32'(grant), 32'b0010);
    set_data(0, 70, 50, 6);
    req = 4'b0011;
    for (int s = 2; s <= 2 * (WH + 3) + 1; s++) begin
      step();
      if (s == WH + 2) chk("fair_done1", 32'(done), 32'b0010);
      if (s == WH + 4) chk("fair_second", 32'(grant), 32'b0001);
      if (s == 2 * WH + 5) chk("fair_done0", 32'(done), 32'b0001);
      if (s == 2 * WH + 7) chk("fair_third", 32'(grant), 32'b0010);
    end
    $display("[TB] fairness sequence complete");
    req = '0;
    for (int s = 0; s < 40; s++) step();

    // ---- randomized traffic against the model ----
    for (int t = 0; t < 3000; t++) begin
      reset_n = ($urandom_range(0, 699) != 0);
      for (int i = 0; i < N; i++) begin
        if (req[i] && e_done[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
          set_data(i,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(145, 170) : $urandom_range(0, 255),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 127),
                   $urandom_range(0, 7));
        end else if (req[i] && $urandom_range(0, 15) == 0) begin
          req_x[8*i +: 8] = 8'($urandom_range(0, 255));
        end
      end
      step();
    end
    $display("[TB] random phase complete at step %0d", step_no);
    reset_n = 1'b1;
    req = '0;
    for (int s = 0; s < 40; s++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
